// File: rtl/ifu_pkg.sv
// Shared types, limits and helpers for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned IFU_DEPTH_MAX = 16;
  localparam int unsigned IFU_DATA_W    = 32;
  localparam int unsigned IFU_ADDR_W    = 11;

  // One queue slot: fetched word plus the word address it came from
  typedef struct packed {
    logic [IFU_DATA_W-1:0] instr;
    logic [IFU_ADDR_W-1:0] pc;
  } ifu_entry_t;

  // Width needed to hold an occupancy count of 0..depth
  function automatic int unsigned ifu_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bus: instruction RAM port, decoder handshake, redirect and perf counters.
interface ifu_if
  import ifu_pkg::*;
#(
  parameter int unsigned DATA_W = IFU_DATA_W,
  parameter int unsigned ADDR_W = IFU_ADDR_W
);

  logic              fetch_en;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [31:0]       perf_bubbles;
  logic [31:0]       perf_redirects;

  // Fetch unit side
  modport master (
    input  fetch_en, mem_rdata, instr_ready, redirect, redirect_pc,
    output mem_rd_en, mem_addr, instr_valid, instr_out, instr_pc,
           perf_bubbles, perf_redirects
  );

  // RAM / controller side
  modport slave (
    output fetch_en, mem_rdata, instr_ready, redirect, redirect_pc,
    input  mem_rd_en, mem_addr, instr_valid, instr_out, instr_pc,
           perf_bubbles, perf_redirects
  );

endinterface

// File: rtl/ifu_queue.sv
// DEPTH-entry circular buffer with push, pop, flush and occupancy count.
// The head output holds the last popped entry while the queue is empty.
module ifu_queue
  import ifu_pkg::*;
#(
  parameter int unsigned WIDTH = IFU_DATA_W + IFU_ADDR_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = ifu_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & ~empty_o;
  assign count_o = count_q;
  assign rdata_o = empty_o ? last_q : mem_q[rd_ptr_q];

  // Pointer, count and last-popped next-state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        last_d   = mem_q[rd_ptr_q];
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // Storage; contents are only observed through a valid pointer
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited reads to a
// 1-cycle synchronous RAM, queues responses and hands them out over valid/ready.
// Optional build macro IFU_PERF_EN adds saturating bubble/redirect counters.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned       DATA_W   = IFU_DATA_W,
  parameter int unsigned       ADDR_W   = IFU_ADDR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic   clk,
  input logic   rst_n,
  ifu_if.master bus
);

  localparam int unsigned CNT_W   = ifu_cnt_w(DEPTH);
  localparam int unsigned OCC_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = DATA_W + ADDR_W;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_addr_q, inflight_addr_d;
  logic [CNT_W-1:0]   q_count;
  logic               q_empty;
  logic [ENTRY_W-1:0] q_rdata;
  logic               valid;
  logic               pop;
  logic               push;
  logic               issue;
  logic [OCC_W-1:0]   occ;

  // Handshake and credit: every issued read is guaranteed a free slot
  assign valid = ~q_empty & ~bus.redirect;
  assign pop   = valid & bus.instr_ready;
  assign push  = inflight_q & ~bus.redirect;
  assign occ   = OCC_W'(q_count) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign issue = rst_n & bus.fetch_en & ~bus.redirect & (occ < OCC_W'(DEPTH));

  assign bus.mem_rd_en   = issue;
  assign bus.mem_addr    = pc_q;
  assign bus.instr_valid = valid;
  assign bus.instr_out   = q_rdata[ENTRY_W-1:ADDR_W];
  assign bus.instr_pc    = q_rdata[ADDR_W-1:0];

  // PC and in-flight tracking next-state; redirect overrides issue
  always_comb begin
    pc_d            = pc_q;
    inflight_d      = issue;
    inflight_addr_d = inflight_addr_q;
    if (bus.redirect) begin
      pc_d       = bus.redirect_pc;
      inflight_d = 1'b0;
    end else if (issue) begin
      pc_d            = pc_q + ADDR_W'(1);
      inflight_addr_d = pc_q;
    end
  end

  // PC and in-flight registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q            <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      pc_q            <= pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  ifu_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({bus.mem_rdata, inflight_addr_q}),
    .rdata_o (q_rdata),
    .count_o (q_count),
    .empty_o (q_empty)
  );

`ifdef IFU_PERF_EN
  logic [31:0] bubbles_q, bubbles_d;
  logic [31:0] redirects_q, redirects_d;

  // Saturating performance counters next-state
  always_comb begin
    bubbles_d   = bubbles_q;
    redirects_d = redirects_q;
    if (bus.instr_ready && !valid && (bubbles_q != '1)) bubbles_d = bubbles_q + 32'd1;
    if (bus.redirect && (redirects_q != '1))            redirects_d = redirects_q + 32'd1;
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubbles_q   <= '0;
      redirects_q <= '0;
    end else begin
      bubbles_q   <= bubbles_d;
      redirects_q <= redirects_d;
    end
  end

  assign bus.perf_bubbles   = bubbles_q;
  assign bus.perf_redirects = redirects_q;
`else
  assign bus.perf_bubbles   = '0;
  assign bus.perf_redirects = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (DEPTH=4, ADDR_W=11, RESET_PC=0).
// RAM model returns 0xE000_0000 + address one cycle after each read strobe.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DEPTH  = 4;

`ifdef IFU_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ram_q = '0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          issues;

  always #5 clk = ~clk;

  ifu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  instr_fetch_unit #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (11'h000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous instruction RAM model
  always @(posedge clk) begin
    if (bus.mem_rd_en) ram_q <= 32'hE000_0000 + 32'(bus.mem_addr);
  end
  assign bus.mem_rdata = ram_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic ifu_entry_t ent(input logic [ADDR_W-1:0] pc);
    ifu_entry_t e;
    e.instr = 32'hE000_0000 + 32'(pc);
    e.pc    = pc;
    return e;
  endfunction

  task automatic check_head(input string tag, input logic [ADDR_W-1:0] pc);
    ifu_entry_t e;
    e = ent(pc);
    check({tag, "_valid"}, 64'(bus.instr_valid), 64'd1);
    check(tag, 64'({bus.instr_out, bus.instr_pc}), 64'(e));
  endtask

  function automatic logic [63:0] perf_exp(input int n);
    return PERF ? 64'(n) : 64'd0;
  endfunction

  initial begin
    rst_n           = 1'b0;
    bus.fetch_en    = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    repeat (3) tick();
    settle();
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_addr",  64'(bus.mem_addr), 64'd0);
    check("rst_out",   64'(bus.instr_out), 64'd0);
    check("rst_pc",    64'(bus.instr_pc), 64'd0);
    check("rst_perf_b", 64'(bus.perf_bubbles), 64'd0);
    check("rst_perf_r", 64'(bus.perf_redirects), 64'd0);

    // Reset release and streaming
    tick(); rst_n = 1'b1; bus.fetch_en = 1'b1; bus.instr_ready = 1'b1; settle();
    check("t1_rd_en_c0", 64'(bus.mem_rd_en), 64'd1);
    check("t1_addr_c0",  64'(bus.mem_addr), 64'd0);
    check("t1_valid_c0", 64'(bus.instr_valid), 64'd0);
    tick(); settle();
    check("t1_valid_c1", 64'(bus.instr_valid), 64'd0);
    check("t1_addr_c1",  64'(bus.mem_addr), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      check_head("t1_head", ADDR_W'(i));
    end

    // Back-pressure fills exactly DEPTH entries, then drains in order
    tick(); bus.instr_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = '0; settle();
    check("t2_redir_valid", 64'(bus.instr_valid), 64'd0);
    tick(); bus.redirect = 1'b0; settle();
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_rd_en) issues++;
      tick(); settle();
    end
    check("t2_issues", 64'(issues), 64'd4);
    check("t2_rd_en_full", 64'(bus.mem_rd_en), 64'd0);
    check_head("t2_hold", 11'h000);
    bus.instr_ready = 1'b1; settle();
    for (int i = 0; i < 6; i++) begin
      check_head("t2_drain", ADDR_W'(i));
      tick(); settle();
    end

    // Redirect with 3 queued and one read in flight
    bus.instr_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 11'h020; settle();
    tick(); bus.redirect = 1'b0; settle();
    check("t3_addr_pre", 64'(bus.mem_addr), 64'h020);
    repeat (4) tick();
    settle();
    check_head("t3_pre_head", 11'h020);
    check("t3_rd_en_pre", 64'(bus.mem_rd_en), 64'd0);
    bus.redirect = 1'b1; bus.redirect_pc = 11'h100; bus.instr_ready = 1'b1; settle();
    check("t3_valid_redir", 64'(bus.instr_valid), 64'd0);
    check("t3_rd_en_redir", 64'(bus.mem_rd_en), 64'd0);
    tick(); bus.redirect = 1'b0; settle();
    check("t3_rd_en_r1", 64'(bus.mem_rd_en), 64'd1);
    check("t3_addr_r1",  64'(bus.mem_addr), 64'h100);
    check("t3_valid_r1", 64'(bus.instr_valid), 64'd0);
    tick(); settle();
    check("t3_valid_r2", 64'(bus.instr_valid), 64'd0);
    tick(); settle();
    check_head("t3_first", 11'h100);
    tick(); settle();
    check_head("t3_second", 11'h101);

    // PC wrap from 0x7FF to 0x000
    tick(); bus.redirect = 1'b1; bus.redirect_pc = 11'h7FE; settle();
    tick(); bus.redirect = 1'b0; settle();
    tick(); settle();
    check("t4_addr_7ff", 64'(bus.mem_addr), 64'h7FF);
    tick(); settle();
    check("t4_addr_wrap", 64'(bus.mem_addr), 64'h000);
    check_head("t4_head_7fe", 11'h7FE);
    tick(); settle();
    check_head("t4_head_7ff", 11'h7FF);
    tick(); settle();
    check_head("t4_head_000", 11'h000);

    // Mid-stream reset with a read in flight
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; settle();
    check("t5_valid_c0", 64'(bus.instr_valid), 64'd0);
    check("t5_addr_c0",  64'(bus.mem_addr), 64'd0);
    check("t5_rd_en_c0", 64'(bus.mem_rd_en), 64'd1);
    tick(); settle();
    check("t5_valid_c1", 64'(bus.instr_valid), 64'd0);
    check("t5_addr_c1",  64'(bus.mem_addr), 64'd1);
    tick(); settle();
    check_head("t5_first", 11'h000);

    // Performance counters: 5 idle bubbles, then 2 back-to-back redirects
    tick(); rst_n = 1'b0; bus.fetch_en = 1'b0; bus.instr_ready = 1'b0; settle();
    tick(); rst_n = 1'b1; bus.instr_ready = 1'b1; settle();
    check("t6_b_c0", 64'(bus.perf_bubbles), 64'd0);
    repeat (5) tick();
    settle();
    check("t6_b_c5", 64'(bus.perf_bubbles), perf_exp(5));
    check("t6_r_c5", 64'(bus.perf_redirects), 64'd0);
    bus.redirect = 1'b1; bus.redirect_pc = 11'h050;
    tick(); bus.redirect_pc = 11'h060;
    tick(); bus.redirect = 1'b0; bus.instr_ready = 1'b0; bus.fetch_en = 1'b1; settle();
    check("t6_b_c7", 64'(bus.perf_bubbles), perf_exp(7));
    check("t6_r_c7", 64'(bus.perf_redirects), perf_exp(2));
    check("t6_last_redir_addr", 64'(bus.mem_addr), 64'h060);
    check("t6_last_redir_rd_en", 64'(bus.mem_rd_en), 64'd1);
    tick(); settle();
    check("t6_b_c8", 64'(bus.perf_bubbles), perf_exp(7));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
